// File: rtl/aes128_pkg.sv
// Shared AES-128 definitions: round constants, sequencer states
// and the GF(2^8) xtime helper used by Rcon and MixColumns.
package aes128_pkg;

    localparam int          NUM_ROUNDS_AES128 = 10;
    localparam logic [7:0]  RCON_INIT         = 8'h01;
    localparam logic [7:0]  RCON_POLY         = 8'h1B;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ROUND,
        FINAL,
        DONE
    } aesState_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 round sequencer: drives load/enable strobes,
// round index and Rcon for an external combinational round datapath.
module aes128_round_ctrl
    import aes128_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_AES128,
    parameter int ROUND_W    = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start_valid,
    output logic               o_start_ready,
    output logic               o_done_valid,
    input  logic               i_done_ready,
    input  logic               i_flush,
    output logic               o_load,
    output logic               o_state_en,
    output logic               o_key_en,
    output logic               o_mix_en,
    output logic [ROUND_W-1:0] o_round,
    output logic [7:0]         o_rcon,
    output logic               o_busy
);

    localparam logic [ROUND_W-1:0] LAST_FULL = ROUND_W'(NUM_ROUNDS - 1);
    localparam logic [ROUND_W-1:0] LAST_IDX  = ROUND_W'(NUM_ROUNDS);
    localparam logic [ROUND_W-1:0] ONE       = ROUND_W'(1);

    aesState_e          state;
    aesState_e          stateNext;
    logic [ROUND_W-1:0] roundCnt;
    logic [ROUND_W-1:0] roundCntNext;
    logic [7:0]         rconReg;
    logic [7:0]         rconNext;
    logic               startReady;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            roundCnt <= '0;
            rconReg  <= RCON_INIT;
        end else begin
            state    <= stateNext;
            roundCnt <= roundCntNext;
            rconReg  <= rconNext;
        end
    end

    always_comb begin
        stateNext    = state;
        roundCntNext = roundCnt;
        rconNext     = rconReg;
        o_load       = 1'b0;
        o_state_en   = 1'b0;
        o_key_en     = 1'b0;
        o_mix_en     = 1'b0;
        o_round      = '0;
        o_rcon       = 8'h00;
        o_done_valid = 1'b0;
        o_busy       = 1'b0;
        startReady   = !i_flush &&
                       (state == IDLE || (state == DONE && i_done_ready));

        unique case (state)
            IDLE: begin
                if (i_start_valid && startReady) stateNext = INIT;
            end
            INIT: begin
                o_load       = 1'b1;
                o_state_en   = 1'b1;
                o_key_en     = 1'b1;
                o_mix_en     = 1'b1;
                o_busy       = 1'b1;
                roundCntNext = ONE;
                rconNext     = RCON_INIT;
                stateNext    = (NUM_ROUNDS == 1) ? FINAL : ROUND;
            end
            ROUND: begin
                o_state_en   = 1'b1;
                o_key_en     = 1'b1;
                o_mix_en     = 1'b1;
                o_busy       = 1'b1;
                o_round      = roundCnt;
                o_rcon       = rconReg;
                roundCntNext = roundCnt + ONE;
                rconNext     = xtime(rconReg);
                if (roundCnt == LAST_FULL) stateNext = FINAL;
            end
            FINAL: begin
                o_state_en = 1'b1;
                o_key_en   = 1'b1;
                o_busy     = 1'b1;
                o_round    = LAST_IDX;
                o_rcon     = rconReg;
                stateNext  = DONE;
            end
            DONE: begin
                o_done_valid = 1'b1;
                if (i_done_ready) stateNext = i_start_valid ? INIT : IDLE;
            end
            default: stateNext = IDLE;
        endcase

        // Abort wins over everything and must not disturb the datapath.
        if (i_flush) begin
            stateNext    = IDLE;
            roundCntNext = '0;
            rconNext     = RCON_INIT;
            o_load       = 1'b0;
            o_state_en   = 1'b0;
            o_key_en     = 1'b0;
        end
    end

    assign o_start_ready = startReady;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Bench for aes128_round_ctrl: a behavioural AES datapath follows
// the strobes, and a phase-count reference model checks each cycle.
module tb_aes128_round_ctrl;

    typedef struct {
        logic       load;
        logic       en;
        logic       mix;
        logic       done;
        logic       busy;
        logic       sr;
        logic [3:0] round;
        logic [7:0] rcon;
    } vec_t;

    logic clk = 1'b0;
    logic rstN = 1'b1;
    logic startValid = 1'b0;
    logic doneReady = 1'b0;
    logic flush = 1'b0;

    logic       startReady, doneValid, load, stateEn, keyEn, mixEn, busy;
    logic [3:0] round;
    logic [7:0] rcon;

    logic [127:0] pt = '0;
    logic [127:0] key = '0;
    logic [127:0] dpState = '0;
    logic [127:0] dpKey = '0;

    logic [7:0] sboxT [256];
    logic [7:0] rconSeq [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    int checks = 0;
    int errors = 0;

    aes128_round_ctrl dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_start_valid(startValid),
        .o_start_ready(startReady),
        .o_done_valid (doneValid),
        .i_done_ready (doneReady),
        .i_flush      (flush),
        .o_load       (load),
        .o_state_en   (stateEn),
        .o_key_en     (keyEn),
        .o_mix_en     (mixEn),
        .o_round      (round),
        .o_rcon       (rcon),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    function automatic logic [7:0] byteOf(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] subShift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = sboxT[byteOf(s, r + 4*((c+r)%4))];
        return o;
    endfunction

    function automatic logic [127:0] mixCols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = byteOf(s, 4*c);
            a1 = byteOf(s, 4*c+1);
            a2 = byteOf(s, 4*c+2);
            a3 = byteOf(s, 4*c+3);
            o[127-8*(4*c)   -: 8] = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
            o[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
            o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
            o[127-8*(4*c+3) -: 8] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
        end
        return o;
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {w3[23:0], w3[31:24]};
        t  = {sboxT[t[31:24]], sboxT[t[23:16]], sboxT[t[15:8]], sboxT[t[7:0]]};
        t  = t ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] roundF(input logic [127:0] s,
                                            input logic [127:0] k,
                                            input logic mix);
        logic [127:0] t;
        t = subShift(s);
        if (mix) t = mixCols(t);
        return t ^ k;
    endfunction

    function automatic logic [127:0] aesEncrypt(input logic [127:0] p, input logic [127:0] k);
        logic [127:0] s, rk;
        s  = p ^ k;
        rk = k;
        for (int r = 0; r < 10; r++) begin
            rk = expand(rk, rconSeq[r]);
            s  = roundF(s, rk, r != 9);
        end
        return s;
    endfunction

    // Expected outputs from the number of cycles since the start handshake:
    // 0 idle, 1 initial AddRoundKey, 2..11 rounds 1..10, 12 holding result.
    function automatic vec_t model(input int ph, input logic fl, input logic rdy);
        vec_t e;
        e.busy  = (ph >= 1 && ph <= 11);
        e.en    = e.busy && !fl;
        e.load  = (ph == 1) && !fl;
        e.mix   = (ph != 11);
        e.done  = (ph == 12);
        e.sr    = !fl && (ph == 0 || (ph == 12 && rdy));
        e.round = e.busy ? 4'(ph - 1) : 4'd0;
        e.rcon  = (ph >= 2 && ph <= 11) ? rconSeq[ph-2] : 8'h00;
        return e;
    endfunction

    logic       capLoad, capSe, capKe, capMix;
    logic [7:0] capRcon;
    logic [127:0] capPt, capKey;

    always @(negedge clk) begin
        capLoad = load;
        capSe   = stateEn;
        capKe   = keyEn;
        capMix  = mixEn;
        capRcon = rcon;
        capPt   = pt;
        capKey  = key;
    end

    always @(posedge clk) begin
        if (capLoad) begin
            dpState <= capPt ^ capKey;
            dpKey   <= capKey;
        end else begin
            if (capSe) dpState <= roundF(dpState, expand(dpKey, capRcon), capMix);
            if (capKe) dpKey <= expand(dpKey, capRcon);
        end
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic cmpVec(input string tag, input vec_t e);
        chk({tag, ".load"}, load, e.load);
        chk({tag, ".stateEn"}, stateEn, e.en);
        chk({tag, ".keyEn"}, keyEn, e.en);
        chk({tag, ".done"}, doneValid, e.done);
        chk({tag, ".busy"}, busy, e.busy);
        chk({tag, ".startReady"}, startReady, e.sr);
        chk({tag, ".rcon"}, rcon, e.rcon);
        if (e.en) chk({tag, ".mix"}, mixEn, e.mix);
        if (e.busy) chk({tag, ".round"}, round, e.round);
    endtask

    task automatic nextCyc();
        @(posedge clk);
        #1;
    endtask

    task automatic runBlock(input logic [127:0] p, input logic [127:0] k, input string tag);
        pt = p;
        key = k;
        startValid = 1'b1;
        doneReady = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            if (c == 1) startValid = 1'b0;
            if (c == 12) doneReady = 1'b1;
            @(negedge clk);
            if (c >= 2 && c <= 11) chk({tag, ".rconSeq"}, rcon, rconSeq[c-2]);
            if (c == 12) begin
                chk({tag, ".doneAt12"}, doneValid, 1'b1);
                chk({tag, ".cipher"}, dpState, aesEncrypt(p, k));
            end
            nextCyc();
        end
        doneReady = 1'b0;
    endtask

    vec_t tbl [1:12];

    initial begin
        vec_t         e;
        int           phase;
        logic [127:0] p2, k2, expCt;

        tbl[1]  = '{1, 1, 1, 0, 1, 0, 4'd0,  8'h00};
        tbl[2]  = '{0, 1, 1, 0, 1, 0, 4'd1,  8'h01};
        tbl[3]  = '{0, 1, 1, 0, 1, 0, 4'd2,  8'h02};
        tbl[4]  = '{0, 1, 1, 0, 1, 0, 4'd3,  8'h04};
        tbl[5]  = '{0, 1, 1, 0, 1, 0, 4'd4,  8'h08};
        tbl[6]  = '{0, 1, 1, 0, 1, 0, 4'd5,  8'h10};
        tbl[7]  = '{0, 1, 1, 0, 1, 0, 4'd6,  8'h20};
        tbl[8]  = '{0, 1, 1, 0, 1, 0, 4'd7,  8'h40};
        tbl[9]  = '{0, 1, 1, 0, 1, 0, 4'd8,  8'h80};
        tbl[10] = '{0, 1, 1, 0, 1, 0, 4'd9,  8'h1B};
        tbl[11] = '{0, 1, 0, 0, 1, 0, 4'd10, 8'h36};
        tbl[12] = '{0, 0, 0, 1, 0, 0, 4'd0,  8'h00};

        for (int v = 0; v < 256; v++) begin
            logic [7:0] inv;
            inv = 8'h00;
            if (v != 0) begin
                inv = 8'h01;
                for (int j = 0; j < 254; j++) inv = gmul(inv, 8'(v));
            end
            sboxT[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                       ^ rotl8(inv, 4) ^ 8'h63;
        end

        // Reset state
        #2 rstN = 1'b0;
        @(negedge clk);
        e = model(0, 1'b0, 1'b0);
        cmpVec("reset", e);
        chk("reset.round", round, 4'd0);
        chk("reset.mix", mixEn, 1'b0);
        nextCyc();
        rstN = 1'b1;

        // Directed FIPS-197 run against the per-cycle table
        pt = FIPS_PT;
        key = FIPS_KEY;
        startValid = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            if (k == 1) startValid = 1'b0;
            @(negedge clk);
            if (k == 0) chk("dir.startReady", startReady, 1'b1);
            else cmpVec($sformatf("dir.c%0d", k), tbl[k]);
            if (k == 12) chk("dir.cipher", dpState, FIPS_CT);
            if (k < 12) nextCyc();
        end

        // Backpressure: result held, start ignored
        startValid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            nextCyc();
            @(negedge clk);
            chk("bp.done", doneValid, 1'b1);
            chk("bp.stateEn", stateEn, 1'b0);
            chk("bp.keyEn", keyEn, 1'b0);
            chk("bp.startReady", startReady, 1'b0);
            chk("bp.cipher", dpState, FIPS_CT);
        end
        nextCyc();
        startValid = 1'b0;
        doneReady = 1'b1;
        @(negedge clk);
        chk("bp.accept.done", doneValid, 1'b1);
        chk("bp.accept.startReady", startReady, 1'b1);
        nextCyc();
        doneReady = 1'b0;
        @(negedge clk);
        chk("bp.idle.busy", busy, 1'b0);
        chk("bp.idle.done", doneValid, 1'b0);
        chk("bp.idle.load", load, 1'b0);

        // Back-to-back: second result 24 cycles after the first start
        nextCyc();
        p2 = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        pt = FIPS_PT;
        key = FIPS_KEY;
        startValid = 1'b1;
        doneReady = 1'b1;
        for (int k = 0; k <= 24; k++) begin
            if (k == 13) begin
                pt = p2;
                key = k2;
            end
            if (k == 14) startValid = 1'b0;
            @(negedge clk);
            if (k == 11) chk("b2b.notYet", doneValid, 1'b0);
            if (k == 12) begin
                chk("b2b.done1", doneValid, 1'b1);
                chk("b2b.cipher1", dpState, FIPS_CT);
                chk("b2b.startReady", startReady, 1'b1);
            end
            if (k == 13) chk("b2b.load", load, 1'b1);
            if (k == 23) chk("b2b.notYet2", doneValid, 1'b0);
            if (k == 24) begin
                chk("b2b.done2", doneValid, 1'b1);
                chk("b2b.cipher2", dpState, aesEncrypt(p2, k2));
            end
            nextCyc();
        end
        doneReady = 1'b0;
        @(negedge clk);
        chk("b2b.idle", busy, 1'b0);

        // Flush in round 5, start in the flush cycle is refused
        nextCyc();
        pt = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        startValid = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            if (c == 1) startValid = 1'b0;
            if (c == 6) begin
                flush = 1'b1;
                startValid = 1'b1;
            end
            if (c == 7) begin
                flush = 1'b0;
                startValid = 1'b0;
            end
            @(negedge clk);
            if (c == 6) begin
                chk("flush.round", round, 4'd5);
                chk("flush.stateEn", stateEn, 1'b0);
                chk("flush.keyEn", keyEn, 1'b0);
                chk("flush.startReady", startReady, 1'b0);
            end
            if (c == 7) begin
                chk("flush.busy", busy, 1'b0);
                chk("flush.done", doneValid, 1'b0);
                chk("flush.load", load, 1'b0);
                chk("flush.idleReady", startReady, 1'b1);
            end
            nextCyc();
        end
        runBlock({$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, "postFlush");

        // Asynchronous reset in the middle of round 7
        pt = FIPS_PT;
        key = FIPS_KEY;
        startValid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c == 1) startValid = 1'b0;
            nextCyc();
        end
        #2 rstN = 1'b0;
        #1;
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", doneValid, 1'b0);
        chk("rst.stateEn", stateEn, 1'b0);
        chk("rst.round", round, 4'd0);
        chk("rst.rcon", rcon, 8'h00);
        chk("rst.startReady", startReady, 1'b1);
        nextCyc();
        rstN = 1'b1;
        runBlock(FIPS_PT, FIPS_KEY, "postRst");

        // Random handshakes and flushes against the phase model
        phase = 0;
        expCt = '0;
        for (int n = 0; n < 2000; n++) begin
            startValid = ($urandom_range(0, 3) == 0);
            doneReady  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 49) == 0);
            if (phase == 0) begin
                pt = {$urandom, $urandom, $urandom, $urandom};
                key = {$urandom, $urandom, $urandom, $urandom};
                expCt = aesEncrypt(pt, key);
            end
            @(negedge clk);
            e = model(phase, flush, doneReady);
            cmpVec("rand", e);
            if (phase == 12) chk("rand.cipher", dpState, expCt);
            if (flush) phase = 0;
            else if (phase == 0) phase = startValid ? 1 : 0;
            else if (phase < 12) phase = phase + 1;
            else if (doneReady) phase = startValid ? 1 : 0;
            nextCyc();
        end
        startValid = 1'b0;
        doneReady = 1'b0;
        flush = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes128_round_ctrl.md
Name: aes128_round_ctrl

Overview:
- Iterative AES-128 encryption sequencer that drives the round datapath: the state register, key register, SubBytes/ShiftRows/MixColumns/AddRoundKey chain and key-expansion step.
- Accepts a start request, runs the initial AddRoundKey, then 9 full rounds and 1 final round without MixColumns.
- Generates the per-round Rcon, load and enable strobes, and a round index, and then holds a done/valid until the consumer accepts it.
- The datapath itself stays purely combinational plus two 128-bit registers enabled by this block.

Parameters:
- NUM_ROUNDS, 10, total rounds after the initial AddRoundKey. Legal range is 1..10; values below 10 are for reduced-round debug only.
- ROUND_W, 4, width of the round counter/index. It must satisfy 2^ROUND_W > NUM_ROUNDS.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_start_valid  in  1  plaintext/key present on datapath inputs
- o_start_ready  out  1  block can accept start. Combinational: IDLE, or DONE with i_done_ready=1.
- o_done_valid  out  1  datapath state register holds ciphertext
- i_done_ready  in  1  consumer accepts ciphertext
- i_flush  in  1  synchronous abort back to IDLE
- o_load  out  1  datapath muxes: state <= plaintext^key, key <= cipher key
- o_state_en  out  1  state register enable
- o_key_en  out  1  key register enable
- o_mix_en  out  1  1 = MixColumns in path; 0 = bypass (final round)
- o_round  out  ROUND_W  current round index, 0 = initial AddRoundKey
- o_rcon  out  8  Rcon byte for the key expansion of the current round
- o_busy  out  1  1 in INIT/ROUND/FINAL

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE, round counter=0, Rcon register=8'h01.
  - All strobes 0, o_done_valid=0, o_round=0, o_rcon=8'h00, o_busy=0.
  - o_start_ready=1 (IDLE).
- States: IDLE, INIT, ROUND, FINAL, DONE. Encoding comes from the shared package.
- IDLE:
  - on i_start_valid & o_start_ready -> INIT; otherwise stay.
- INIT (1 cycle):
  - o_load=1, o_state_en=1, o_key_en=1, o_round=0, o_mix_en=x (drive 1).
  - Next state is ROUND, or FINAL if NUM_ROUNDS=1.
  - Counter <= 1, Rcon reg = 8'h01.
- ROUND (rounds 1..NUM_ROUNDS-1):
  - o_state_en=1, o_key_en=1, o_mix_en=1, o_round=counter, o_rcon=Rcon reg.
  - Each cycle: counter+1, and Rcon reg <= xtime(Rcon), i.e. {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00).
  - Leave for FINAL when counter == NUM_ROUNDS-1.
- FINAL (1 cycle):
  - o_state_en=1, o_key_en=1, o_mix_en=0, o_round=NUM_ROUNDS, o_rcon=Rcon reg (8'h36 for 10 rounds).
  - -> DONE.
- DONE:
  - o_done_valid=1; all enables 0; o_rcon=0.
  - Datapath registers hold, so the ciphertext stays stable.
  - On i_done_ready: if i_start_valid also -> INIT (back-to-back, no bubble); otherwise -> IDLE.
- Latency (NUM_ROUNDS=10): start handshake in cycle 0, INIT in cycle 1, rounds 1-9 in cycles 2-10, FINAL in cycle 11, o_done_valid=1 from cycle 12.
- Throughput: one block per 12 cycles when the consumer is always ready.
- Rcon sequence driven on rounds 1..10: 01,02,04,08,10,20,40,80,1B,36.
- Outside ROUND/FINAL, o_rcon=0.
- i_flush:
  - Priority over all transitions, in any state: next state IDLE, counter=0, Rcon=01, no enables in the flush cycle.
  - A DONE result is dropped.
  - A start presented in the same cycle as flush is not accepted; o_start_ready is forced to 0 while i_flush=1.
- Backpressure: i_done_ready=0 holds DONE indefinitely; no start is accepted during that time.
- i_start_valid while busy is ignored (o_start_ready=0); the requester holds it.
- Reset mid-operation: the run is abandoned immediately. The datapath register content is don't-care, because o_done_valid=0.

Decomposition:
- Shared package aes128_pkg holds:
  - NUM_ROUNDS_AES128=10, RCON_INIT=8'h01, RCON_POLY=8'h1B
  - the state enum (IDLE, INIT, ROUND, FINAL, DONE)
  - an xtime function, reused by MixColumns.
- No sub-module; xtime is a package function. Only the FSM, counter and Rcon register live here.

Test Plan:
- Reset, then a start with plaintext 00112233445566778899aabbccddeeff and key 000102030405060708090a0b0c0d0e0f, through the full datapath -> o_done_valid at cycle 12 with state 69c4e0d86a7b0430d8cdb78070b4c55a.
- Same run, monitor strobes -> o_load only in cycle 1; o_rcon over cycles 2-11 = 01,02,04,08,10,20,40,80,1B,36; o_mix_en=0 only in cycle 11; o_round 0..10.
- i_done_ready=0 for 20 cycles after done -> o_done_valid held, enables 0, ciphertext stable, o_start_ready=0; accepted on the cycle ready rises.
- In DONE, i_done_ready=1 and i_start_valid=1 together -> next cycle INIT (o_load=1), second ciphertext at cycle 24 relative to the first start.
- i_flush asserted in cycle 6 (round 5) -> IDLE next cycle, o_busy=0, no o_done_valid. A fresh start then yields the correct ciphertext and an Rcon sequence restarting at 01.
- i_rst_n low during cycle 8 -> all outputs return to reset values asynchronously. After release a new start completes normally in 12 cycles.
